// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter.
// Sends a latched pattern of 1..PAT_W bits MSB-first, repeated a
// programmable number of times with programmable idle gaps between repetitions.
// All outputs are registered. The first bit appears one cycle after an accepted start.
module seq_pattern_tx #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             o,
    output logic             o_valid,
    output logic             first,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // PAT_W widened by one bit so that pat_len values above PAT_W compare correctly.
    localparam logic [LEN_W:0] PAT_W_L = (LEN_W + 1)'(PAT_W);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [GAP_W-1:0]   gap_cfg_q, gap_cfg_d;
    logic [LEN_W-1:0]   bit_idx_q, bit_idx_d;   // index of the bit on o this cycle
    logic [REP_W-1:0]   rep_left_q, rep_left_d; // repetitions left, current one included
    logic [GAP_W-1:0]   gap_left_q, gap_left_d; // gap cycles left after this one

    logic o_q, o_d;
    logic o_valid_q, o_valid_d;
    logic first_q, first_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic             args_legal;
    logic [PAT_W-1:0] pat_src;

    // Select one pattern bit by a run-time index without an out-of-range part select.
    function automatic logic pat_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) == idx) begin
                r = p[i];
            end
        end
        return r;
    endfunction

    assign args_legal = (pat_len != '0) && ({1'b0, pat_len} <= PAT_W_L) && (reps != '0);

    // In IDLE the pattern is being latched on this same edge, so read it straight from the input.
    assign pat_src = (state_q == S_IDLE) ? pattern : pat_q;

    // State, configuration, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            gap_cfg_q  <= '0;
            bit_idx_q  <= '0;
            rep_left_q <= '0;
            gap_left_q <= '0;
            o_q        <= 1'b0;
            o_valid_q  <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            gap_cfg_q  <= gap_cfg_d;
            bit_idx_q  <= bit_idx_d;
            rep_left_q <= rep_left_d;
            gap_left_q <= gap_left_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next state and counter updates; counters only move when non-zero so they never wrap.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        gap_cfg_d  = gap_cfg_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_left_d = gap_left_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort && args_legal) begin
                    state_d    = S_SEND;
                    pat_d      = pattern;
                    len_d      = pat_len;
                    gap_cfg_d  = gap;
                    rep_left_d = reps;
                    bit_idx_d  = pat_len - LEN_W'(1);
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - LEN_W'(1);
                end else if (rep_left_q > REP_W'(1)) begin
                    if (gap_cfg_q != '0) begin
                        // This cycle is the first gap cycle, so gap-1 remain after it.
                        state_d    = S_GAP;
                        gap_left_d = gap_cfg_q - GAP_W'(1);
                    end else begin
                        bit_idx_d  = len_q - LEN_W'(1);
                        rep_left_d = rep_left_q - REP_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_left_q == '0) begin
                    state_d    = S_SEND;
                    bit_idx_d  = len_q - LEN_W'(1);
                    rep_left_d = rep_left_q - REP_W'(1);
                end else begin
                    gap_left_d = gap_left_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered output values for the cycle following this edge.
    always_comb begin
        o_valid_d = (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE);
        // A repetition starts when entering SEND, or when SEND wraps from bit 0 without a gap.
        first_d   = o_valid_d && ((state_q != S_SEND) || (bit_idx_q == '0));
        o_d       = o_valid_d && pat_bit(pat_src, bit_idx_d);
        done_d    = (state_q == S_SEND) && (state_d == S_IDLE) && !abort;
        err_d     = (state_q == S_IDLE) && start && !abort && !args_legal;
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign first   = first_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences. Output vectors are packed {o,o_valid,first,busy,done,err}.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       o, o_valid, first, busy, done, err;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] rp;
        logic [3:0] gp;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    seq_pattern_tx #(
        .PAT_W(8),
        .LEN_W(4),
        .REP_W(4),
        .GAP_W(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .pat_len (pat_len),
        .reps    (reps),
        .gap     (gap),
        .o       (o),
        .o_valid (o_valid),
        .first   (first),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {o, o_valid, first, busy, done, err};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got o/v/f/b/d/e=%b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: o/v/f/b/d/e=%b", name, act);
        end
    endtask

    task automatic add(input logic st, input logic ab, input logic [7:0] pat,
                       input logic [3:0] len, input logic [3:0] rp, input logic [3:0] gp,
                       input logic [5:0] exp);
        vec_t v;
        v.st = st; v.ab = ab; v.pat = pat; v.len = len; v.rp = rp; v.gp = gp; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Run n cycles; bit (n-1-c) of each mask is the expectation for cycle c.
    // With drop_start set, start is released and all arguments are scrambled after the first edge.
    task automatic check_cycles(input string name, input int n, input logic drop_start,
                                input logic [31:0] eo, input logic [31:0] ev,
                                input logic [31:0] ef, input logic [31:0] eb,
                                input logic [31:0] ed);
        for (int c = 0; c < n; c++) begin
            step();
            cmp($sformatf("%s[%0d]", name, c),
                {eo[n-1-c], ev[n-1-c], ef[n-1-c], eb[n-1-c], ed[n-1-c], 1'b0});
            if (drop_start && c == 0) begin
                start   = 1'b0;
                pattern = ~pattern;
                pat_len = 4'd1;
                reps    = 4'd9;
                gap     = 4'd7;
            end
        end
    endtask

    task automatic go_idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; pat_len = '0; reps = '0; gap = '0;

        // Vector table: inputs before an edge, outputs expected after it.
        // test 1: 1011, len 4, one repetition
        add(1, 0, 8'h0B, 4, 1, 0, 6'b111100);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b010100);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b110100);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b110100);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b000010);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b000000);
        // illegal arguments: pat_len 0, pat_len 9, reps 0
        add(1, 0, 8'h0B, 0, 1, 0, 6'b000001);
        add(0, 0, 8'h0B, 0, 1, 0, 6'b000000);
        add(1, 0, 8'h0B, 9, 1, 0, 6'b000001);
        add(0, 0, 8'h0B, 9, 1, 0, 6'b000000);
        add(1, 0, 8'h0B, 4, 0, 0, 6'b000001);
        add(0, 0, 8'h0B, 4, 0, 0, 6'b000000);
        // abort with start in IDLE wins; abort alone in IDLE does nothing
        add(1, 1, 8'h0B, 4, 1, 0, 6'b000000);
        add(0, 1, 8'h0B, 4, 1, 0, 6'b000000);
        add(1, 1, 8'h0B, 0, 1, 0, 6'b000000);
        // abort at edge k+2 of a test-1 frame
        add(1, 0, 8'h0B, 4, 1, 0, 6'b111100);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b010100);
        add(0, 1, 8'h0B, 4, 1, 0, 6'b000000);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b000000);
        add(0, 0, 8'h0B, 4, 1, 0, 6'b000000);
        // abort during a gap: pattern 10, 2 reps, gap 3
        add(1, 0, 8'h02, 2, 2, 3, 6'b111100);
        add(0, 0, 8'h02, 2, 2, 3, 6'b010100);
        add(0, 0, 8'h02, 2, 2, 3, 6'b000100);
        add(0, 1, 8'h02, 2, 2, 3, 6'b000000);
        add(0, 0, 8'h02, 2, 2, 3, 6'b000000);

        step();
        step();
        cmp("reset_state", 6'b000000);
        rst = 1'b0;
        step();
        cmp("idle_after_reset", 6'b000000);

        for (int i = 0; i < vecs.size(); i++) begin
            start   = vecs[i].st;
            abort   = vecs[i].ab;
            pattern = vecs[i].pat;
            pat_len = vecs[i].len;
            reps    = vecs[i].rp;
            gap     = vecs[i].gp;
            step();
            cmp($sformatf("vec%0d", i), vecs[i].exp);
        end
        go_idle(2);

        // test 2: 110 x3 with gap 2, inputs scrambled after start
        pattern = 8'b0000_0110; pat_len = 4'd3; reps = 4'd3; gap = 4'd2; start = 1'b1;
        check_cycles("gap2", 15, 1'b1,
                     32'b110001100011000, 32'b111001110011100,
                     32'b100001000010000, 32'b111111111111100,
                     32'b000000000000010);
        go_idle(2);

        // test 6: A5 x2 without gap, 16 contiguous bits
        pattern = 8'hA5; pat_len = 4'd8; reps = 4'd2; gap = 4'd0; start = 1'b1;
        check_cycles("a5x2", 18, 1'b1,
                     {16'hA5A5, 2'b00}, {16'hFFFF, 2'b00},
                     {16'h8080, 2'b00}, {16'hFFFF, 2'b00},
                     {16'h0000, 2'b10});
        go_idle(2);

        // test 5: start held high: ignored while busy, accepted in the done cycle
        pattern = 8'h0B; pat_len = 4'd4; reps = 4'd1; gap = 4'd0; start = 1'b1;
        check_cycles("held_start", 10, 1'b0,
                     32'b1011010110, 32'b1111011110,
                     32'b1000010000, 32'b1111011110,
                     32'b0000100001);
        go_idle(2);

        // reset at edge k+2 of a test-1 frame
        pattern = 8'h0B; pat_len = 4'd4; reps = 4'd1; gap = 4'd0; start = 1'b1;
        step();
        cmp("rst_frame_c0", 6'b111100);
        start = 1'b0;
        step();
        cmp("rst_frame_c1", 6'b010100);
        rst = 1'b1;
        start = 1'b1;
        step();
        cmp("rst_mid_frame", 6'b000000);
        rst = 1'b0;
        start = 1'b0;
        step();
        cmp("after_rst", 6'b000000);
        step();
        cmp("after_rst_no_done", 6'b000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
